id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline stage that registers decoded instructions from ID and presents resolved operands, ALU control and downstream control bits to the 32-bit ALU in EX. It contains the ID/EX pipeline register, the EX-side operand forwarding muxes and the load-use interlock. It sits between instruction decode and the ALU / EX-MEM register of the 5-stage CPU.

## Interface
- DATA_W, 32, operand and result width
- REG_AW, 5, register address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs_data_i, id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW  source and destination register numbers
- id_alu_ctrl_i  in  3  ALU op: ADD 000, SUB 001, MUL 010, AND 011, OR 100
- id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1  decoded controls
- hold_i  in  1  freeze the whole stage (memory wait)
- flush_i  in  1  kill the instruction in ID (taken branch)
- exmem_regwrite_i, memwb_regwrite_i  in  1  writer valid in MEM / WB
- exmem_rd_i, memwb_rd_i  in  REG_AW  destination in MEM / WB
- exmem_data_i, memwb_data_i  in  DATA_W  result in MEM / WB
- stall_o  out  1  load-use interlock; PC and IF/ID must hold
- data0_o, data1_o  out  DATA_W  ALU operands
- ALUCtrl_o  out  3  ALU op
- store_data_o  out  DATA_W  forwarded rt value for stores
- rd_o  out  REG_AW; valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o  out  1  to EX/MEM

## Operation
- Per-edge update priority: hold_i (register unchanged) > flush_i (load bubble) > stall_o (load bubble) > normal load from ID.
- Bubble: valid, regwrite, memread, memwrite, memtoreg = 0; rs, rt, rd = 0; ALU op ADD; data fields 0.
- An ID instruction with id_valid_i=0 loads as a bubble.
- Forwarding of registered rs (and likewise rt): exmem_regwrite_i && exmem_rd_i==rs && rs!=0 selects exmem_data_i; else the same test on MEM/WB selects memwb_data_i; else the registered value. MEM has priority over WB.
- data0_o = forwarded rs. data1_o = alusrc ? registered imm : forwarded rt. store_data_o = forwarded rt, always.
- Load-use: stall_o = id_valid_i && valid && memread && rd!=0 && (rd==id_rs_i || rd==id_rt_i). Register 0 never causes a hazard.
- Register file writes in the first half-cycle, so a WB-stage writer never needs a stall.

## Timing
- ID to outputs: 1 cycle latency. Forwarding muxes and stall_o are combinational, valid in the same cycle.
- Load-use costs exactly one bubble cycle. On the next cycle the load is in MEM, so the dependent operand is forwarded from exmem_data_i only if MEM supplies load data there; otherwise the operand comes from MEM/WB one cycle later via a second stall asserted by the pipeline control.
- hold_i with flush_i: the flush is not applied. Upstream keeps flush_i asserted until hold_i drops.
- stall_o stays combinational while hold_i is high. The register does not change.
- Reset: all registered fields 0, valid_o 0, ALUCtrl_o 000, all outputs 0, stall_o 0. Reset asserted mid-instruction discards it at once, with no partial state.

## Configuration
- ID_EX_FWD_EN defined: forwarding and the one-cycle load-use interlock as above.
- ID_EX_FWD_EN undefined: no forwarding muxes. Operands come from the registered values.
  - stall_o asserts on any RAW hazard (rs or rt, nonzero) against the EX-stage writer (registered rd/regwrite) or the MEM-stage writer (exmem_rd_i/exmem_regwrite_i).
  - stall_o asserts for up to 2 cycles per dependency.

## Structure
- Package ex_pkg:
  - ALU op constants ADD/SUB/MUL/AND/OR.
  - DATA_W/REG_AW defaults.
  - Packed struct for the control bundle (valid, regwrite, memread, memwrite, memtoreg, alusrc, alu_ctrl).
- Sub-module hazard_detect holds the stall_o logic for both configurations.
- Forwarding muxes and the register stay in id_ex_stage.

## Test plan
- Reset: hold rst_i low, drive ID inputs -> all outputs 0, valid_o 0, stall_o 0. Release, load ADD rs=1 (5), rt=2 (7) -> next cycle data0_o=5, data1_o=7, ALUCtrl_o=000.
- Forwarding priority: EX holds rs=3. exmem (rd=3, 0x10) and memwb (rd=3, 0x20) both writing -> data0_o=0x10. Drop exmem_regwrite_i -> data0_o=0x20.
- Register 0: rs=0, exmem writes rd=0 with 0xFFFF -> data0_o=0, no stall.
- Load-use: LW rd=4 in EX, ID SUB rs=4 -> stall_o=1 for one cycle, the next registered instruction is a bubble (valid_o=0), then SUB loads.
- Hold/flush: hold_i=1 with flush_i=1 -> outputs unchanged. hold_i=0 with flush_i=1 -> bubble next cycle.
- Without ID_EX_FWD_EN: ADD rd=5 in EX, ID OR rs=5 -> stall_o high 2 cycles, then OR loads with the register-file value.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and helpers for the ID/EX stage: ALU op encodings, default
// widths, the registered control bundle and the operand forwarding rule.
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_MUL = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic    valid;
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    memtoreg;
        logic    alusrc;
        alu_op_e alu_ctrl;
    } ctrl_t;

    // Full contents of the ID/EX pipeline register.
    typedef struct packed {
        ctrl_t              ctrl;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
    } id_ex_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        valid: 1'b0, regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
        memtoreg: 1'b0, alusrc: 1'b0, alu_ctrl: ALU_ADD
    };

    localparam id_ex_t ID_EX_BUBBLE = '{
        ctrl: CTRL_BUBBLE, rs: '0, rt: '0, rd: '0,
        rs_data: '0, rt_data: '0, imm: '0
    };

    // Pick the youngest in-flight producer of src; register 0 is never forwarded
    // because it is hardwired to zero in the register file.
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [REG_AW-1:0] src,
        input logic [DATA_W-1:0] reg_val,
        input logic              mem_we,
        input logic [REG_AW-1:0] mem_rd,
        input logic [DATA_W-1:0] mem_data,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (mem_we && (mem_rd == src) && (src != '0)) return mem_data;
        if (wb_we && (wb_rd == src) && (src != '0))   return wb_data;
        return reg_val;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of everything the ID/EX stage exchanges with decode, the later
// pipeline stages and the ALU. master = surrounding pipeline, slave = stage.
interface id_ex_stage_if;
    import ex_pkg::*;

    // From ID
    logic              id_valid_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic [2:0]        id_alu_ctrl_i;
    logic              id_alusrc_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              id_memwrite_i;
    logic              id_memtoreg_i;

    // Pipeline control
    logic              hold_i;
    logic              flush_i;

    // Writers further down the pipe
    logic              exmem_regwrite_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic [DATA_W-1:0] exmem_data_i;
    logic              memwb_regwrite_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [DATA_W-1:0] memwb_data_i;

    // To ALU and EX/MEM
    logic              stall_o;
    logic [DATA_W-1:0] data0_o;
    logic [DATA_W-1:0] data1_o;
    logic [2:0]        ALUCtrl_o;
    logic [DATA_W-1:0] store_data_o;
    logic [REG_AW-1:0] rd_o;
    logic              valid_o;
    logic              regwrite_o;
    logic              memread_o;
    logic              memwrite_o;
    logic              memtoreg_o;

    modport master (
        output id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_alu_ctrl_i,
               id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               hold_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_data_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        input  stall_o, data0_o, data1_o, ALUCtrl_o, store_data_o,
               rd_o, valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o
    );

    modport slave (
        input  id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
               id_rs_i, id_rt_i, id_rd_i, id_alu_ctrl_i,
               id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               hold_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_data_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        output stall_o, data0_o, data1_o, ALUCtrl_o, store_data_o,
               rd_o, valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o
    );

endinterface

// File: rtl/hazard_detect.sv
// Stall generation for the ID/EX stage.
// ID_EX_FWD_EN defined  : only a load in EX feeding the ID instruction stalls.
// ID_EX_FWD_EN undefined: any writer in EX or MEM feeding the ID instruction
//                         stalls, giving up to two stall cycles per dependency.
module hazard_detect
    import ex_pkg::*;
(
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              exmem_regwrite_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    output logic              stall_o
);

    // True when a writer to rd produces a source of the ID instruction.
    function automatic logic feeds_id(input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rt);
        return (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

`ifdef ID_EX_FWD_EN
    logic w_unused;

    assign w_unused = ^{ex_regwrite_i, exmem_regwrite_i, exmem_rd_i};
    assign stall_o  = id_valid_i && ex_valid_i && ex_memread_i
                      && feeds_id(ex_rd_i, id_rs_i, id_rt_i);
`else
    logic w_ex_raw;
    logic w_mem_raw;
    logic w_unused;

    assign w_unused  = ex_memread_i;
    assign w_ex_raw  = ex_valid_i && ex_regwrite_i && feeds_id(ex_rd_i, id_rs_i, id_rt_i);
    assign w_mem_raw = exmem_regwrite_i && feeds_id(exmem_rd_i, id_rs_i, id_rt_i);
    assign stall_o   = id_valid_i && (w_ex_raw || w_mem_raw);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: pipeline register, EX-side operand forwarding and
// load-use interlock feeding the 32-bit ALU.
// Forwarding is compiled in when ID_EX_FWD_EN is defined; otherwise operands
// come straight from the register and hazards are resolved by stalling.
module id_ex_stage
    import ex_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    id_ex_stage_if.slave bus
);

    id_ex_t            r_ex;
    id_ex_t            w_id;
    logic              w_stall;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // Pack the ID-side inputs into the register layout.
    always_comb begin
        // NOTE: a full default first keeps this block free of inferred latches.
        w_id                = ID_EX_BUBBLE;
        w_id.ctrl.valid     = bus.id_valid_i;
        w_id.ctrl.regwrite  = bus.id_regwrite_i;
        w_id.ctrl.memread   = bus.id_memread_i;
        w_id.ctrl.memwrite  = bus.id_memwrite_i;
        w_id.ctrl.memtoreg  = bus.id_memtoreg_i;
        w_id.ctrl.alusrc    = bus.id_alusrc_i;
        w_id.ctrl.alu_ctrl  = alu_op_e'(bus.id_alu_ctrl_i);
        w_id.rs             = bus.id_rs_i;
        w_id.rt             = bus.id_rt_i;
        w_id.rd             = bus.id_rd_i;
        w_id.rs_data        = bus.id_rs_data_i;
        w_id.rt_data        = bus.id_rt_data_i;
        w_id.imm            = bus.id_imm_i;
    end

    hazard_detect u_hazard (
        .id_valid_i       (bus.id_valid_i),
        .id_rs_i          (bus.id_rs_i),
        .id_rt_i          (bus.id_rt_i),
        .ex_valid_i       (r_ex.ctrl.valid),
        .ex_regwrite_i    (r_ex.ctrl.regwrite),
        .ex_memread_i     (r_ex.ctrl.memread),
        .ex_rd_i          (r_ex.rd),
        .exmem_regwrite_i (bus.exmem_regwrite_i),
        .exmem_rd_i       (bus.exmem_rd_i),
        .stall_o          (w_stall)
    );

    // ID/EX register: hold freezes, flush/stall/invalid ID insert a bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_ex <= ID_EX_BUBBLE;
        end else if (bus.hold_i) begin
            r_ex <= r_ex;
        end else if (bus.flush_i || w_stall || !bus.id_valid_i) begin
            r_ex <= ID_EX_BUBBLE;
        end else begin
            r_ex <= w_id;
        end
    end

`ifdef ID_EX_FWD_EN
    assign w_fwd_rs = fwd_operand(r_ex.rs, r_ex.rs_data,
                                  bus.exmem_regwrite_i, bus.exmem_rd_i, bus.exmem_data_i,
                                  bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);
    assign w_fwd_rt = fwd_operand(r_ex.rt, r_ex.rt_data,
                                  bus.exmem_regwrite_i, bus.exmem_rd_i, bus.exmem_data_i,
                                  bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i);
`else
    // Without forwarding the source numbers and later-stage results are not consumed.
    logic w_unused_fwd;

    assign w_unused_fwd = ^{r_ex.rs, r_ex.rt, bus.exmem_data_i,
                            bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i};
    assign w_fwd_rs     = r_ex.rs_data;
    assign w_fwd_rt     = r_ex.rt_data;
`endif

    assign bus.stall_o      = w_stall;
    assign bus.data0_o      = w_fwd_rs;
    assign bus.data1_o      = r_ex.ctrl.alusrc ? r_ex.imm : w_fwd_rt;
    assign bus.store_data_o = w_fwd_rt;
    assign bus.ALUCtrl_o    = r_ex.ctrl.alu_ctrl;
    assign bus.rd_o         = r_ex.rd;
    assign bus.valid_o      = r_ex.ctrl.valid;
    assign bus.regwrite_o   = r_ex.ctrl.regwrite;
    assign bus.memread_o    = r_ex.ctrl.memread;
    assign bus.memwrite_o   = r_ex.ctrl.memwrite;
    assign bus.memtoreg_o   = r_ex.ctrl.memtoreg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies one stimulus per cycle,
// predicts the stage outputs from an instruction-level model and queues them;
// the monitor compares the DUT outputs against the queue at the falling edge.
module tb_id_ex_stage;
    import ex_pkg::*;

`ifdef ID_EX_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct {
        bit          rst_n;
        bit          id_valid;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [2:0]  alu;
        bit          alusrc, regwrite, memread, memwrite, memtoreg;
        bit          hold, flush;
        bit          exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_data;
        bit          mwb_we;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_data;
    } stim_t;

    // Instruction sitting in EX, as the model sees it.
    typedef struct {
        bit          valid;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rs_data, rt_data, imm;
        logic [2:0]  alu;
        bit          alusrc, regwrite, memread, memwrite, memtoreg;
    } instr_t;

    typedef struct {
        bit          stall;
        logic [31:0] d0, d1, st;
        logic [2:0]  alu;
        logic [4:0]  rd;
        bit          valid, regw, memr, memw, m2r;
    } exp_t;

    logic   clk_i = 1'b0;
    logic   rst_i = 1'b0;
    exp_t   exp_q[$];
    instr_t m_ex;
    instr_t m_next;
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     drv_done = 1'b0;
    stim_t  s;

    always #5 clk_i = ~clk_i;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_operand(input logic [4:0] r, input logic [31:0] v,
                                              input stim_t st);
        if (FWD_EN && r != 0 && st.exm_we && st.exm_rd == r) return st.exm_data;
        if (FWD_EN && r != 0 && st.mwb_we && st.mwb_rd == r) return st.mwb_data;
        return v;
    endfunction

    function automatic bit m_dep(input logic [4:0] w, input stim_t st);
        return (w != 0) && (w == st.rs || w == st.rt);
    endfunction

    function automatic bit m_stall(input instr_t ex, input stim_t st);
        if (!st.rst_n || !st.id_valid) return 1'b0;
        if (FWD_EN) return ex.valid && ex.memread && m_dep(ex.rd, st);
        return (ex.valid && ex.regwrite && m_dep(ex.rd, st)) || (st.exm_we && m_dep(st.exm_rd, st));
    endfunction

    function automatic exp_t m_expect(input instr_t ex, input stim_t st);
        exp_t        e;
        logic [31:0] rt_op;
        rt_op   = m_operand(ex.rt, ex.rt_data, st);
        e.stall = m_stall(ex, st);
        e.d0    = m_operand(ex.rs, ex.rs_data, st);
        e.d1    = ex.alusrc ? ex.imm : rt_op;
        e.st    = rt_op;
        e.alu   = ex.alu;
        e.rd    = ex.rd;
        e.valid = ex.valid;
        e.regw  = ex.regwrite;
        e.memr  = ex.memread;
        e.memw  = ex.memwrite;
        e.m2r   = ex.memtoreg;
        return e;
    endfunction

    function automatic instr_t m_advance(input instr_t ex, input stim_t st);
        instr_t n;
        n = '{default: '0};
        if (!st.rst_n) return n;
        if (st.hold) return ex;
        if (st.flush || m_stall(ex, st) || !st.id_valid) return n;
        n.valid    = 1'b1;
        n.rs       = st.rs;      n.rt      = st.rt;      n.rd  = st.rd;
        n.rs_data  = st.rs_data; n.rt_data = st.rt_data; n.imm = st.imm;
        n.alu      = st.alu;     n.alusrc  = st.alusrc;
        n.regwrite = st.regwrite; n.memread = st.memread;
        n.memwrite = st.memwrite; n.memtoreg = st.memtoreg;
        return n;
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle();
        stim_t t;
        t       = '{default: '0};
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic stim_t mk(input logic [2:0] alu, input logic [4:0] rs, rt, rd,
                                 input logic [31:0] rsd, rtd);
        stim_t t;
        t          = idle();
        t.id_valid = 1'b1;
        t.regwrite = 1'b1;
        t.alu      = alu;
        t.rs       = rs;  t.rt      = rt;  t.rd = rd;
        t.rs_data  = rsd; t.rt_data = rtd;
        return t;
    endfunction

    task automatic drive(input stim_t st);
        rst_i                = st.rst_n;
        bus.id_valid_i       = st.id_valid;
        bus.id_rs_data_i     = st.rs_data;
        bus.id_rt_data_i     = st.rt_data;
        bus.id_imm_i         = st.imm;
        bus.id_rs_i          = st.rs;
        bus.id_rt_i          = st.rt;
        bus.id_rd_i          = st.rd;
        bus.id_alu_ctrl_i    = st.alu;
        bus.id_alusrc_i      = st.alusrc;
        bus.id_regwrite_i    = st.regwrite;
        bus.id_memread_i     = st.memread;
        bus.id_memwrite_i    = st.memwrite;
        bus.id_memtoreg_i    = st.memtoreg;
        bus.hold_i           = st.hold;
        bus.flush_i          = st.flush;
        bus.exmem_regwrite_i = st.exm_we;
        bus.exmem_rd_i       = st.exm_rd;
        bus.exmem_data_i     = st.exm_data;
        bus.memwb_regwrite_i = st.mwb_we;
        bus.memwb_rd_i       = st.mwb_rd;
        bus.memwb_data_i     = st.mwb_data;
    endtask

    // One cycle: advance model at the edge, apply inputs, queue the prediction.
    task automatic step(input stim_t st);
        @(posedge clk_i);
        m_ex = m_next;
        #1;
        drive(st);
        if (!st.rst_n) m_ex = '{default: '0};
        exp_q.push_back(m_expect(m_ex, st));
        m_next = m_advance(m_ex, st);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        while (!drv_done || exp_q.size() != 0) begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("stall_o",      32'(bus.stall_o),      32'(e.stall));
                check("data0_o",      bus.data0_o,           e.d0);
                check("data1_o",      bus.data1_o,           e.d1);
                check("store_data_o", bus.store_data_o,      e.st);
                check("ALUCtrl_o",    32'(bus.ALUCtrl_o),    32'(e.alu));
                check("rd_o",         32'(bus.rd_o),         32'(e.rd));
                check("valid_o",      32'(bus.valid_o),      32'(e.valid));
                check("regwrite_o",   32'(bus.regwrite_o),   32'(e.regw));
                check("memread_o",    32'(bus.memread_o),    32'(e.memr));
                check("memwrite_o",   32'(bus.memwrite_o),   32'(e.memw));
                check("memtoreg_o",   32'(bus.memtoreg_o),   32'(e.m2r));
            end
        end
    end

    // ---------------- driver ----------------
    initial begin : driver
        int guard;
        m_ex   = '{default: '0};
        m_next = '{default: '0};
        s = idle();
        s.rst_n = 1'b0;
        drive(s);

        // Reset with an instruction presented on ID: everything stays zero.
        s = mk(ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        s.rst_n = 1'b0;
        step(s);
        step(s);
        // Release and load ADD r1(5), r2(7).
        s.rst_n = 1'b1;
        step(s);
        step(idle());

        // Forwarding priority on rs=3, held in EX.
        step(mk(ALU_ADD, 5'd3, 5'd0, 5'd6, 32'h33, 32'h0));
        s = idle();
        s.hold   = 1'b1;
        s.exm_we = 1'b1; s.exm_rd = 5'd3; s.exm_data = 32'h10;
        s.mwb_we = 1'b1; s.mwb_rd = 5'd3; s.mwb_data = 32'h20;
        step(s);
        s.exm_we = 1'b0;
        step(s);

        // Register 0 is never forwarded and never stalls.
        step(mk(ALU_ADD, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0));
        s = mk(ALU_AND, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0);
        s.exm_we = 1'b1; s.exm_rd = 5'd0; s.exm_data = 32'hFFFF;
        step(s);

        // Load-use: LW r4 in EX, SUB r4 in ID.
        s = mk(ALU_ADD, 5'd1, 5'd0, 5'd4, 32'h100, 32'h0);
        s.alusrc = 1'b1; s.imm = 32'd8; s.memread = 1'b1; s.memtoreg = 1'b1;
        step(s);
        s = mk(ALU_SUB, 5'd4, 5'd2, 5'd9, 32'h11, 32'h22);
        step(s);
        s.exm_we = 1'b1; s.exm_rd = 5'd4; s.exm_data = 32'h44;
        step(s);
        s = mk(ALU_SUB, 5'd4, 5'd2, 5'd9, 32'h44, 32'h22);
        s.mwb_we = 1'b1; s.mwb_rd = 5'd4; s.mwb_data = 32'h44;
        step(s);
        step(idle());

        // Hold beats flush; flush alone inserts a bubble.
        step(mk(ALU_OR, 5'd1, 5'd2, 5'd10, 32'hA, 32'hB));
        s = mk(ALU_AND, 5'd3, 5'd6, 5'd11, 32'hC, 32'hD);
        s.hold = 1'b1; s.flush = 1'b1;
        step(s);
        step(s);
        s.hold = 1'b0;
        step(s);
        step(idle());

        // ALU writer r5 in EX, OR reads r5.
        step(mk(ALU_ADD, 5'd1, 5'd2, 5'd5, 32'd1, 32'd2));
        s = mk(ALU_OR, 5'd5, 5'd6, 5'd12, 32'h55, 32'h66);
        step(s);
        s.exm_we = 1'b1; s.exm_rd = 5'd5; s.exm_data = 32'd3;
        step(s);
        s.exm_we = 1'b0; s.mwb_we = 1'b1; s.mwb_rd = 5'd5; s.mwb_data = 32'd3;
        step(s);
        step(idle());

        // Reset in the middle of an instruction discards it at once.
        step(mk(ALU_MUL, 5'd1, 5'd2, 5'd13, 32'h9, 32'h3));
        s = idle(); s.rst_n = 1'b0;
        step(s);
        step(idle());

        // Randomised traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            s          = idle();
            s.rst_n    = ($urandom_range(0, 99) != 0);
            s.id_valid = ($urandom_range(0, 3) != 0);
            s.rs       = 5'($urandom_range(0, 7));
            s.rt       = 5'($urandom_range(0, 7));
            s.rd       = 5'($urandom_range(0, 7));
            s.rs_data  = $urandom;
            s.rt_data  = $urandom;
            s.imm      = $urandom;
            s.alu      = 3'($urandom_range(0, 4));
            s.alusrc   = 1'($urandom_range(0, 1));
            s.regwrite = 1'($urandom_range(0, 1));
            s.memread  = 1'($urandom_range(0, 1));
            s.memwrite = 1'($urandom_range(0, 1));
            s.memtoreg = 1'($urandom_range(0, 1));
            s.hold     = ($urandom_range(0, 7) == 0);
            s.flush    = ($urandom_range(0, 7) == 0);
            s.exm_we   = 1'($urandom_range(0, 1));
            s.exm_rd   = 5'($urandom_range(0, 7));
            s.exm_data = $urandom;
            s.mwb_we   = 1'($urandom_range(0, 1));
            s.mwb_rd   = 5'($urandom_range(0, 7));
            s.mwb_data = $urandom;
            step(s);
        end

        drv_done = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk_i);
            guard++;
        end
        @(posedge clk_i);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
